// File: rtl/stream_fifo_pkg.sv
// Shared types and helpers for the stream FIFO: pointer typedef, output-stage
// states and read-latency constant.
package stream_fifo_pkg;

  localparam int RD_LATENCY     = 1;
  localparam int MAX_ADDR_WIDTH = 24;

  // Widest supported pointer; modules narrow it to ADDR_WIDTH+1 bits locally.
  typedef logic [MAX_ADDR_WIDTH:0] ptr_max_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } out_state_e;

  function automatic ptr_max_t ptr_addr_mask(input int aw);
    return (ptr_max_t'(1) << aw) - ptr_max_t'(1);
  endfunction

  function automatic ptr_max_t ptr_wrap_mask(input int aw);
    return ptr_max_t'(1) << aw;
  endfunction

  // Equal wrap bits and equal addresses: nothing stored.
  function automatic logic ptr_empty(input ptr_max_t wr, input ptr_max_t rd, input int aw);
    return ((wr & ptr_wrap_mask(aw)) == (rd & ptr_wrap_mask(aw))) &&
           ((wr & ptr_addr_mask(aw)) == (rd & ptr_addr_mask(aw)));
  endfunction

  // Opposite wrap bits and equal addresses: every location holds a word.
  function automatic logic ptr_full(input ptr_max_t wr, input ptr_max_t rd, input int aw);
    return ((wr & ptr_wrap_mask(aw)) != (rd & ptr_wrap_mask(aw))) &&
           ((wr & ptr_addr_mask(aw)) == (rd & ptr_addr_mask(aw)));
  endfunction

endpackage

// File: rtl/fifo_bram_sdp.sv
// Simple dual-port block RAM: one write port, one registered read port with
// read enable (one cycle read latency).
module fifo_bram_sdp
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo.sv
// Valid/ready stream FIFO over block RAM with a two-word first-word-fall-through
// output stage. Define STREAM_FIFO_ERROR_FLAGS_EN to add sticky overflow/underflow flags.
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int AFULL_LEVEL  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH:0]   count,
`ifdef STREAM_FIFO_ERROR_FLAGS_EN
  input  logic                  err_clear,
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int DEPTH       = 2**ADDR_WIDTH;
  localparam int STAGE_SLOTS = 1 + RD_LATENCY;

  typedef logic [ADDR_WIDTH:0] ptr_t;
  typedef logic [ADDR_WIDTH:0] cnt_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t AFULL_C  = cnt_t'(AFULL_LEVEL);
  localparam cnt_t AEMPTY_C = cnt_t'(AEMPTY_LEVEL);

  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  out_state_e            out_state;
  logic                  rd_pending;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  push;
  logic                  pop;
  logic                  wr_en;
  logic                  rd_en;
  logic                  mem_empty;
  logic                  mem_full;
  logic [2:0]            stage_occ;
  cnt_t                  count_next;

  assign m_valid   = (out_state != EMPTY);
  assign push      = s_valid & s_ready;
  assign pop       = m_valid & m_ready;
  assign mem_empty = ptr_empty(ptr_max_t'(wr_ptr), ptr_max_t'(rd_ptr), ADDR_WIDTH);
  assign mem_full  = ptr_full(ptr_max_t'(wr_ptr), ptr_max_t'(rd_ptr), ADDR_WIDTH);
  assign wr_en     = push & ~mem_full;

  // Words held or in flight toward the output stage once this edge's pop is done;
  // a new read is only launched if it will still find a free slot on arrival.
  assign stage_occ = {1'b0, out_state} + {2'b00, rd_pending} - {2'b00, pop};
  assign rd_en     = ~mem_empty & (stage_occ < 3'(STAGE_SLOTS));

  fifo_bram_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data (ram_rdata)
  );

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + cnt_t'(1);
    else if (pop && !push) count_next = count - cnt_t'(1);
  end

  // Pointers, occupancy, flags and the output stage advance together; the
  // flags and s_ready come from count_next so they line up with count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      rd_pending   <= 1'b0;
      out_state    <= EMPTY;
      m_data       <= '0;
      skid_data    <= '0;
      count        <= '0;
      s_ready      <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
      if (rd_en) rd_ptr <= rd_ptr + ptr_t'(1);
      rd_pending   <= rd_en;
      count        <= count_next;
      s_ready      <= (count_next < DEPTH_C);
      almost_full  <= (count_next >= AFULL_C);
      almost_empty <= (count_next <= AEMPTY_C);

      case (out_state)
        EMPTY: begin
          if (rd_pending) begin
            m_data    <= ram_rdata;
            out_state <= ONE;
          end
        end
        ONE: begin
          if (pop) begin
            if (rd_pending) m_data <= ram_rdata;
            else            out_state <= EMPTY;
          end else if (rd_pending) begin
            skid_data <= ram_rdata;
            out_state <= TWO;
          end
        end
        TWO: begin
          if (pop) begin
            m_data <= skid_data;
            if (rd_pending) skid_data <= ram_rdata;
            else            out_state <= ONE;
          end
        end
        default: out_state <= EMPTY;
      endcase
    end
  end

`ifdef STREAM_FIFO_ERROR_FLAGS_EN
  // Sticky error flags; a new error in the clearing cycle keeps its flag set.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (overflow  & ~err_clear) | (s_valid & ~s_ready);
      underflow <= (underflow & ~err_clear) | (m_ready & ~m_valid);
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed-vector bench for stream_fifo with a queue scoreboard for popped data.
// Error-flag checks are compiled only with STREAM_FIFO_ERROR_FLAGS_EN.
module tb_stream_fifo;

  localparam int DW     = 8;
  localparam int AW     = 10;
  localparam int DEPTH  = 1024;
  localparam int AFULL  = 1020;
  localparam int AEMPTY = 4;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          m_ready = 1'b0;
  logic [DW-1:0] s_data  = '0;
  logic          s_ready;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
`ifdef STREAM_FIFO_ERROR_FLAGS_EN
  logic          err_clear = 1'b0;
  logic          overflow;
  logic          underflow;
`endif

  int            total     = 0;
  int            bad       = 0;
  int            model_cnt = 0;
  int            pop_total = 0;
  logic          last_push = 1'b0;
  logic [DW-1:0] model_q[$];

  typedef struct {
    logic          sv;
    logic [DW-1:0] d;
    logic          mr;
    logic [AW:0]   e_cnt;
    logic          e_mv;
    logic [DW-1:0] e_dat;
    logic          chk_dat;
  } vec_t;

  vec_t vecs [16];

  stream_fifo #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .AFULL_LEVEL  (AFULL),
    .AEMPTY_LEVEL (AEMPTY)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .count        (count),
`ifdef STREAM_FIFO_ERROR_FLAGS_EN
    .err_clear    (err_clear),
    .overflow     (overflow),
    .underflow    (underflow),
`endif
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached before the test ended");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, update the scoreboard, then check occupancy and flags.
  task automatic applyStimulus(input logic sv, input logic [DW-1:0] d, input logic mr);
    logic          do_push;
    logic          do_pop;
    logic [DW-1:0] exp_d;
    s_valid = sv;
    s_data  = d;
    m_ready = mr;
    do_push = sv && (model_cnt < DEPTH);
    do_pop  = m_valid && mr;
    if (do_pop) begin
      if (model_q.size() == 0) begin
        checkOutput("pop_while_empty", 32'(1), 32'(0));
      end else begin
        exp_d = model_q.pop_front();
        checkOutput("pop_data", 32'(m_data), 32'(exp_d));
        pop_total++;
      end
    end
    if (do_push) model_q.push_back(d);
    model_cnt = model_cnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    last_push = do_push;
    @(posedge clk);
    #1;
    checkOutput("count", 32'(count), 32'(model_cnt));
    checkOutput("s_ready", 32'(s_ready), 32'(model_cnt < DEPTH));
    checkOutput("almost_full", 32'(almost_full), 32'(model_cnt >= AFULL));
    checkOutput("almost_empty", 32'(almost_empty), 32'(model_cnt <= AEMPTY));
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    s_data  = '0;
`ifdef STREAM_FIFO_ERROR_FLAGS_EN
    err_clear = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_q.delete();
    model_cnt = 0;
    pop_total = 0;
  endtask

  initial begin
    int   pushed;
    int   bubbles;
    logic started;

    vecs[0]  = '{1'b0, 8'h00, 1'b0, 11'd0, 1'b0, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 8'hA5, 1'b0, 11'd1, 1'b0, 8'h00, 1'b1};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 11'd1, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 11'd1, 1'b1, 8'hA5, 1'b1};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 11'd1, 1'b1, 8'hA5, 1'b1};
    vecs[5]  = '{1'b1, 8'h3C, 1'b0, 11'd2, 1'b1, 8'hA5, 1'b1};
    vecs[6]  = '{1'b1, 8'h7E, 1'b0, 11'd3, 1'b1, 8'hA5, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 1'b0, 11'd3, 1'b1, 8'hA5, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 11'd2, 1'b1, 8'h3C, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b1, 11'd1, 1'b1, 8'h7E, 1'b1};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 11'd0, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 1'b1, 11'd0, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 8'h11, 1'b1, 11'd1, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b1, 11'd1, 1'b0, 8'h00, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 1'b1, 11'd1, 1'b1, 8'h11, 1'b1};
    vecs[15] = '{1'b0, 8'h00, 1'b1, 11'd0, 1'b0, 8'h00, 1'b0};

    // Reset state
    doReset();
    checkOutput("rst_count", 32'(count), 32'(0));
    checkOutput("rst_s_ready", 32'(s_ready), 32'(1));
    checkOutput("rst_m_valid", 32'(m_valid), 32'(0));
    checkOutput("rst_m_data", 32'(m_data), 32'(0));
    checkOutput("rst_almost_empty", 32'(almost_empty), 32'(1));
    checkOutput("rst_almost_full", 32'(almost_full), 32'(0));

    // Table: first-word latency, skid fill, drain, m_ready on empty
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].sv, vecs[i].d, vecs[i].mr);
      checkOutput("vec_count", 32'(count), 32'(vecs[i].e_cnt));
      checkOutput("vec_m_valid", 32'(m_valid), 32'(vecs[i].e_mv));
      if (vecs[i].chk_dat) checkOutput("vec_m_data", 32'(m_data), 32'(vecs[i].e_dat));
    end

    // Head word held stable while the consumer stalls
    doReset();
    applyStimulus(1'b1, 8'hA5, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("hold_m_valid", 32'(m_valid), 32'(1));
      checkOutput("hold_m_data", 32'(m_data), 32'(8'hA5));
      applyStimulus(1'b0, 8'h00, 1'b0);
    end

    // Continuous stream of 2048 words, expect no output bubbles
    doReset();
    pushed  = 0;
    bubbles = 0;
    started = 1'b0;
    for (int cyc = 0; cyc < 4000 && pop_total < 2048; cyc++) begin
      if (started && !m_valid) bubbles++;
      if (m_valid) started = 1'b1;
      applyStimulus(pushed < 2048, 8'(pushed), 1'b1);
      if (last_push) pushed++;
    end
    checkOutput("stream_popped", 32'(pop_total), 32'(2048));
    checkOutput("stream_bubbles", 32'(bubbles), 32'(0));

    // Fill to capacity, reject the extra push, pop one
    doReset();
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      if (i == AFULL - 2) checkOutput("af_below", 32'(almost_full), 32'(0));
      if (i == AFULL - 1) checkOutput("af_at_level", 32'(almost_full), 32'(1));
    end
    checkOutput("full_count", 32'(count), 32'(DEPTH));
    checkOutput("full_s_ready", 32'(s_ready), 32'(0));
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("full_reject_count", 32'(count), 32'(DEPTH));
`ifdef STREAM_FIFO_ERROR_FLAGS_EN
    checkOutput("overflow_set", 32'(overflow), 32'(1));
`endif
    applyStimulus(1'b1, 8'hEF, 1'b1);
    checkOutput("after_pop_count", 32'(count), 32'(DEPTH - 1));
    checkOutput("after_pop_s_ready", 32'(s_ready), 32'(1));
    checkOutput("after_pop_m_data", 32'(m_data), 32'(1));
    for (int k = 0; k < 2000 && model_cnt > 0; k++) applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain_count", 32'(count), 32'(0));
    checkOutput("drain_m_valid", 32'(m_valid), 32'(0));
`ifdef STREAM_FIFO_ERROR_FLAGS_EN
    checkOutput("overflow_sticky", 32'(overflow), 32'(1));
    checkOutput("underflow_clean", 32'(underflow), 32'(0));
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("underflow_set", 32'(underflow), 32'(1));
    err_clear = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0);
    err_clear = 1'b0;
    checkOutput("clear_overflow", 32'(overflow), 32'(0));
    checkOutput("clear_underflow", 32'(underflow), 32'(0));
    err_clear = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1);
    err_clear = 1'b0;
    checkOutput("set_wins_underflow", 32'(underflow), 32'(1));
    checkOutput("set_wins_overflow", 32'(overflow), 32'(0));
`endif

    // Simultaneous push and pop holding occupancy at 5
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 8'(8'h60 + i), 1'b1);
      checkOutput("pp_count", 32'(count), 32'(5));
      checkOutput("pp_almost_empty", 32'(almost_empty), 32'(0));
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("ae_at_4_count", 32'(count), 32'(4));
    checkOutput("ae_at_4", 32'(almost_empty), 32'(1));

    // Reset in the middle of a stream discards everything
    doReset();
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'(8'h80 + i), 1'b1);
    reset_n = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midrst_count", 32'(count), 32'(0));
    checkOutput("midrst_m_valid", 32'(m_valid), 32'(0));
    checkOutput("midrst_m_data", 32'(m_data), 32'(0));
    checkOutput("midrst_s_ready", 32'(s_ready), 32'(1));
`ifdef STREAM_FIFO_ERROR_FLAGS_EN
    checkOutput("midrst_underflow", 32'(underflow), 32'(0));
`endif
    reset_n = 1'b1;
    model_q.delete();
    model_cnt = 0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midrst_no_leftover1", 32'(m_valid), 32'(0));
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("midrst_no_leftover2", 32'(m_valid), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
Name: stream_fifo

Overview:
- Parametrised synchronous FIFO, successor to the plain BRAM FIFO. Adds valid/ready stream handshakes on both sides and first-word-fall-through (FWFT) output via a prefetch stage over block RAM.
- Adds an occupancy count and programmable almost-full/almost-empty flags.
- Sits between the UART/IO front-end and the core, and between pipeline stages that need elastic buffering.

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 10, BRAM address bits. DEPTH = 2**ADDR_WIDTH (localparam) is the total capacity in words.
- AFULL_LEVEL, DEPTH-4, almost_full asserts when count >= AFULL_LEVEL.
- AEMPTY_LEVEL, 4, almost_empty asserts when count <= AEMPTY_LEVEL.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- s_valid  in  1  producer has a word
- s_ready  out  1  FIFO can accept a word
- s_data  in  DATA_WIDTH  write word
- m_valid  out  1  m_data holds the head word
- m_ready  in  1  consumer takes the head word
- m_data  out  DATA_WIDTH  head word, registered
- count  out  ADDR_WIDTH+1  words held: memory plus prefetch, 0..DEPTH
- almost_full  out  1  count >= AFULL_LEVEL
- almost_empty  out  1  count <= AEMPTY_LEVEL

Behaviour:
- Reset: clk is the clock; reset_n is synchronous, active-low. All pointers cleared, count=0, m_valid=0, m_data=0, s_ready=1, almost_empty=1, almost_full=0. Mid-operation reset discards all contents, including the prefetch stage.
- Push: s_valid & s_ready at a rising edge. Pop: m_valid & m_ready at a rising edge. Push and pop may occur in the same cycle.
- s_ready = (count < DEPTH). It is a function of state only; there is no combinational path from m_ready to s_ready.
- m_valid, m_data and the flags are registered or depend on state only.
- Pointers are ADDR_WIDTH+1 bits; the MSB is the wrap bit. Full/empty is decided by comparing the wrap bit and address bits. Pointers wrap modulo 2*DEPTH.
- Read path: BRAM read latency is 1 cycle. The output stage holds up to 2 words (output register plus skid) so that sustained throughput is 1 word/cycle with m_ready held high.
- The BRAM is read whenever memory is non-empty and the output stage will have a free slot after this edge.
- First-word latency: a word pushed at edge t into an empty FIFO gives m_valid=1 after edge t+2. There is no bypass of the BRAM.
- m_data and m_valid stay stable while m_valid & ~m_ready.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. It includes words in the prefetch/output stage.
- Full (count=DEPTH): s_ready=0, and s_valid is ignored even if a pop occurs in the same cycle. s_ready rises the cycle after the pop.
- Empty: m_valid=0, and m_ready is ignored.
- Flags are updated from the next-state count, so they are registered and aligned with count.

Optional Feature:
- Macro: STREAM_FIFO_ERROR_FLAGS_EN.
- With the macro defined, three ports are added:
  - err_clear (in, 1)
  - overflow (out, 1): sticky, set when s_valid=1 while s_ready=0.
  - underflow (out, 1): sticky, set when m_ready=1 while m_valid=0.
- Both flags are cleared by reset or by err_clear. If err_clear and a new error occur in the same cycle, set wins.
- Without the macro, these ports and this logic are absent and behaviour is otherwise identical.

Decomposition:
- Package stream_fifo_pkg holds:
  - typedef for pointer with wrap bit, parametrised via function/localparam helpers.
  - Output-stage state enum: EMPTY, ONE, TWO.
  - Constant for BRAM read latency = 1.
- Sub-module fifo_bram_sdp: simple dual-port RAM, ram_style BLOCK. One write port and one registered read port with read enable.

Test Plan:
- Reset then idle: count=0, s_ready=1, m_valid=0, almost_empty=1, almost_full=0, m_data=0.
- Push 0xA5 at edge t with m_ready=0: m_valid=1 and m_data=0xA5 after edge t+2; count=1; data held stable for 10 cycles.
- Stream 0..2047 with s_valid=m_ready=1 continuously (DATA_WIDTH=8, values mod 256): output sequence is identical and in order; after fill, one pop per cycle with no bubbles.
- Fill 1024 words with m_ready=0: s_ready=0 at count=1024, almost_full from count=1020; one more push is not accepted. Pop one: s_ready=1 the next cycle, count=1023.
- Simultaneous push and pop at count=5 for 100 cycles: count stays 5, almost_empty=0; at count=4, almost_empty=1.
- With STREAM_FIFO_ERROR_FLAGS_EN: push when full sets overflow=1 and it stays set; pop when empty sets underflow=1; err_clear clears both next cycle. Reset pulsed mid-stream: count=0 and m_valid=0 the next cycle.
